cmd_exec: RTL

Parametrised command executor that accepts 32-bit command words over a valid/ready stream, decodes them against the shared command ICD, and applies them to a bank of value registers and an output-select register. Next generation of the fixed 4-bank / 8-bit / 5-bit-output command set: bank count, value width and output width are parameters, and it adds a WAIT command that stalls the stream for a programmed number of cycles. It also detects malformed words and counts them. It sits between the task parser (upstream producer of command words) and the bank/output hardware it configures.

---
 rtl/cmd_icd_pkg.sv | 78 +++++++
 rtl/cmd_wait_timer.sv | 44 ++++
 rtl/cmd_exec.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cmd_icd_pkg.sv
// Shared command ICD: command IDs, field positions, word builders and the
// executor state encoding used by cmd_exec.
package cmd_icd_pkg;

    // Command identifier carried in word[31:28]
    typedef enum logic [3:0] {
        CMD_ID_BANK = 4'b0000,
        CMD_ID_OUT  = 4'b0001,
        CMD_ID_WAIT = 4'b0010
    } cmd_id_t;

    // Executor control states
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } exec_state_t;

    localparam int CMD_ID_LSB = 28;
    localparam int CMD_ID_MSB = 31;

    // BANK: enable mask, unused mask bits, value, reserved upper body
    localparam int BANK_CMD_EN_LSB       = 0;
    localparam int BANK_CMD_EN_MSB       = 3;
    localparam int BANK_CMD_VAL_LSB      = 8;
    localparam int BANK_CMD_VAL_MSB      = 15;
    localparam int BANK_CMD_RESERVED_LSB = 16;
    localparam int BANK_CMD_RESERVED_MSB = 27;

    // OUT: output select, reserved upper body
    localparam int OUT_CMD_SEL_LSB       = 0;
    localparam int OUT_CMD_SEL_MSB       = 4;
    localparam int OUT_CMD_RESERVED_LSB  = 5;
    localparam int OUT_CMD_RESERVED_MSB  = 27;

    // WAIT: stall count, reserved upper body
    localparam int WAIT_CMD_CNT_LSB      = 0;
    localparam int WAIT_CMD_CNT_MSB      = 15;
    localparam int WAIT_CMD_RESERVED_LSB = 16;
    localparam int WAIT_CMD_RESERVED_MSB = 27;

    // Mask with bits lsb..msb set; empty when lsb > msb
    function automatic logic [31:0] field_mask(input int lsb, input int msb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i >= lsb && i <= msb) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] task2bank_cmd(input logic [3:0] en, input logic [7:0] val);
        logic [31:0] w;
        w = '0;
        w[CMD_ID_MSB:CMD_ID_LSB]             = CMD_ID_BANK;
        w[BANK_CMD_EN_MSB:BANK_CMD_EN_LSB]   = en;
        w[BANK_CMD_VAL_MSB:BANK_CMD_VAL_LSB] = val;
        return w;
    endfunction

    function automatic logic [31:0] task2out_cmd(input logic [4:0] sel);
        logic [31:0] w;
        w = '0;
        w[CMD_ID_MSB:CMD_ID_LSB]           = CMD_ID_OUT;
        w[OUT_CMD_SEL_MSB:OUT_CMD_SEL_LSB] = sel;
        return w;
    endfunction

    function automatic logic [31:0] task2wait_cmd(input logic [15:0] n);
        logic [31:0] w;
        w = '0;
        w[CMD_ID_MSB:CMD_ID_LSB]             = CMD_ID_WAIT;
        w[WAIT_CMD_CNT_MSB:WAIT_CMD_CNT_LSB] = n;
        return w;
    endfunction

endpackage

// File: rtl/cmd_wait_timer.sv
// 16-bit load/count/done down-counter that times a WAIT stall and owns busy.
module cmd_wait_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic        busy_o,
    output logic        done_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;

    // Last stall cycle: the count has reached one
    assign done_o = busy_q && (cnt_q == 16'd1);
    assign busy_o = busy_q;

    // Load on a new WAIT, otherwise count down while busy and drop busy at done
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load_i) begin
            cnt_d  = load_val_i;
            busy_d = (load_val_i != 16'd0);
        end else if (busy_q) begin
            cnt_d = cnt_q - 16'd1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    // Counter and busy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/cmd_exec.sv
// Parametrised command executor: decodes ICD command words from a valid/ready
// stream into bank register writes, output-select writes and WAIT stalls,
// rejecting and counting malformed words.
module cmd_exec #(
    parameter int NUM_BANKS = 4,
    parameter int VAL_W     = 8,
    parameter int OUT_W     = 5,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                cmd_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    output logic [NUM_BANKS*VAL_W-1:0] bank_val_o,
    output logic [NUM_BANKS-1:0]       bank_upd_o,
    output logic [OUT_W-1:0]           out_sel_o,
    output logic                       out_upd_o,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [ERR_CNT_W-1:0]       err_cnt_o
);

    import cmd_icd_pkg::*;

    // Field positions derived from the ICD; parameter defaults give the ICD layout
    localparam int EN_LSB   = BANK_CMD_EN_LSB;
    localparam int VAL_LSB  = BANK_CMD_VAL_LSB;
    localparam int SEL_LSB  = OUT_CMD_SEL_LSB;
    localparam int BODY_MSB = BANK_CMD_RESERVED_MSB;

    localparam logic [31:0] BODY_MASK = field_mask(0, BODY_MSB);
    localparam logic [31:0] BANK_USED = field_mask(EN_LSB, EN_LSB + NUM_BANKS - 1)
                                      | field_mask(VAL_LSB, VAL_LSB + VAL_W - 1);
    localparam logic [31:0] OUT_USED  = field_mask(SEL_LSB, SEL_LSB + OUT_W - 1);
    localparam logic [31:0] WAIT_USED = field_mask(WAIT_CMD_CNT_LSB, WAIT_CMD_CNT_MSB);
    localparam logic [31:0] BANK_RSVD = BODY_MASK & ~BANK_USED;
    localparam logic [31:0] OUT_RSVD  = BODY_MASK & ~OUT_USED;
    localparam logic [31:0] WAIT_RSVD = BODY_MASK & ~WAIT_USED;

    exec_state_t state_q, state_d;

    logic [3:0]  cmd_id;
    logic [15:0] wait_n;
    logic        accept;
    logic        id_known;
    logic        rsvd_hit;
    logic        rej;
    logic        bank_wr;
    logic        out_wr;
    logic        wait_ld;
    logic        timer_done;

    logic [NUM_BANKS*VAL_W-1:0] bank_val_q, bank_val_d;
    logic [NUM_BANKS-1:0]       bank_upd_q, bank_upd_d;
    logic [OUT_W-1:0]           out_sel_q, out_sel_d;
    logic                       out_upd_q, out_upd_d;
    logic                       err_q, err_d;
    logic [ERR_CNT_W-1:0]       err_cnt_q, err_cnt_d;

    assign cmd_id = cmd_i[CMD_ID_MSB:CMD_ID_LSB];
    assign wait_n = cmd_i[WAIT_CMD_CNT_MSB:WAIT_CMD_CNT_LSB];
    assign accept = cmd_valid_i && cmd_ready_o;

    // Decode the ID and flag set bits in fields the decoded command does not use
    always_comb begin
        id_known = 1'b1;
        rsvd_hit = 1'b0;
        case (cmd_id)
            CMD_ID_BANK: rsvd_hit = |(cmd_i & BANK_RSVD);
            CMD_ID_OUT:  rsvd_hit = |(cmd_i & OUT_RSVD);
            CMD_ID_WAIT: rsvd_hit = |(cmd_i & WAIT_RSVD);
            default:     id_known = 1'b0;
        endcase
        rej     = accept && (!id_known || rsvd_hit);
        bank_wr = accept && !rej && (cmd_id == CMD_ID_BANK);
        out_wr  = accept && !rej && (cmd_id == CMD_ID_OUT);
        wait_ld = accept && !rej && (cmd_id == CMD_ID_WAIT) && (wait_n != 16'd0);
    end

    cmd_wait_timer u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (wait_ld),
        .load_val_i (wait_n),
        .busy_o     (busy_o),
        .done_o     (timer_done)
    );

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter WAIT on a non-zero WAIT word, leave on the timer's last cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (wait_ld)    state_d = S_WAIT;
            S_WAIT:  if (timer_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is a pure decode of the registered state
    always_comb begin
        cmd_ready_o = (state_q == S_IDLE);
    end

    // Next values for bank/output registers, strobes and the saturating error count
    always_comb begin
        bank_val_d = bank_val_q;
        bank_upd_d = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_wr && cmd_i[EN_LSB + k]) begin
                bank_val_d[k*VAL_W +: VAL_W] = cmd_i[VAL_LSB +: VAL_W];
                bank_upd_d[k]                = 1'b1;
            end
        end
        out_sel_d = out_wr ? cmd_i[SEL_LSB +: OUT_W] : out_sel_q;
        out_upd_d = out_wr;
        err_d     = rej;
        err_cnt_d = err_cnt_q;
        if (rej && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Datapath and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_val_q <= '0;
            bank_upd_q <= '0;
            out_sel_q  <= '0;
            out_upd_q  <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            bank_val_q <= bank_val_d;
            bank_upd_q <= bank_upd_d;
            out_sel_q  <= out_sel_d;
            out_upd_q  <= out_upd_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bank_val_o = bank_val_q;
    assign bank_upd_o = bank_upd_q;
    assign out_sel_o  = out_sel_q;
    assign out_upd_o  = out_upd_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;

endmodule
